// File: rtl/stream_agent.sv
// rtl/stream_agent.sv - Avalon-MM agent pushing host pixel words into a FIFO drained by a valid/ready port
//
// Parameters: DEPTH  FIFO entries (power of two, >= 4)
//             DATA_W Avalon data width (32)
//             ADDR_W Avalon byte address width; only bits [3:2] are decoded
//
// Ports:
//   sys_clk, sys_rst              clock, synchronous active-high reset
//   avs_address/write/read        Avalon-MM request (byte address, word index in [3:2])
//   avs_writedata/byteenable      write payload; byteenable only matters for CTRL
//   avs_readdata                  registered read data, valid on the 2nd read cycle
//   avs_waitrequest               stall: full FIFO on DATA write, first cycle of every read, reset
//   out_data/out_valid/out_ready  FIFO head toward the video path
//
// Word map: 0 DATA (W push), 1 CTRL (W bit0 = clear), 2 STATUS (R), 3 WCOUNT (R)

module stream_agent #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic              avs_read,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] IDX_DATA   = 2'd0;
  localparam logic [1:0] IDX_CTRL   = 2'd1;
  localparam logic [1:0] IDX_STATUS = 2'd2;
  localparam logic [1:0] IDX_WCOUNT = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_RDATA
  } rd_state_t;

  rd_state_t rd_state, rd_state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [31:0]       wcount;

  logic [1:0]        idx;
  logic              full, empty;
  logic              data_wr, push, pop, clear;
  logic              rd_capture, rd_stall;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_bits;

  assign idx   = avs_address[3:2];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // Address bits outside the word index and the upper byte enables carry no meaning here.
  assign unused_bits = ^{avs_address[ADDR_W-1:4], avs_address[1:0], avs_byteenable[3:1]};

  assign data_wr = avs_write && (idx == IDX_DATA);
  // A DATA write completes exactly when it is not stalled by a full FIFO.
  assign push    = data_wr && !full && !sys_rst;
  assign pop     = !empty && out_ready;
  assign clear   = avs_write && (idx == IDX_CTRL) && avs_byteenable[0] && avs_writedata[0];

  // Write stall looks only at registered full, so it never depends on out_ready.
  assign avs_waitrequest = sys_rst || rd_stall || (data_wr && full);

  assign out_data  = mem[rd_ptr];
  assign out_valid = !empty;

  // Storage is not reset; level/pointers decide what is visible.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= avs_writedata;
    end
  end

  // Clear outranks push/pop, so a pop in the clear cycle is simply lost.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      wcount <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        wcount <= wcount + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Read FSM: state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_state <= ST_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  // Read FSM: next state
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      ST_IDLE:  if (avs_read) rd_state_nxt = ST_RDATA;
      ST_RDATA: rd_state_nxt = ST_IDLE;
      default:  rd_state_nxt = ST_IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    rd_capture = 1'b0;
    rd_stall   = 1'b0;
    case (rd_state)
      ST_IDLE: begin
        rd_capture = avs_read;
        rd_stall   = avs_read;
      end
      default: begin
        rd_capture = 1'b0;
        rd_stall   = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_STATUS: begin
        rd_mux[15:0] = 16'(level);
        rd_mux[16]   = full;
        rd_mux[17]   = empty;
      end
      IDX_WCOUNT: rd_mux = DATA_W'(wcount);
      default:    rd_mux = '0;
    endcase
  end

  // Sampled in the IDLE cycle of a read and held until the next read.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      avs_readdata <= '0;
    end else if (rd_capture) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_stream_agent.sv
// tb/tb_stream_agent.sv - self-checking bench for stream_agent

module tb_stream_agent;

  localparam int DEPTH  = 16;
  localparam int BUDGET = 200;

  logic        sys_clk;
  logic        sys_rst;
  logic [31:0] avs_address;
  logic        avs_write;
  logic        avs_read;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  stream_agent #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_read       (avs_read),
    .avs_writedata  (avs_writedata),
    .avs_byteenable (avs_byteenable),
    .avs_readdata   (avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: FIFO contents as a queue, plus counters.
  logic [31:0] mq[$];
  logic [31:0] m_wc;
  logic [31:0] m_rd;
  bit          m_rdata;
  bit          rand_ready;

  bit          wr_done, rd_done;
  logic        s_wait, s_valid;
  logic [31:0] s_rd;

  typedef struct {
    bit          is_rd;
    logic [1:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: no completion within %0d cycles", name, BUDGET);
  endtask

  // One clock: predict, sample at negedge, advance model at posedge.
  task automatic cycle();
    logic [1:0]  idx;
    bit          full_m, exp_wait, exp_valid, clr;
    logic [31:0] rd_next;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    idx       = avs_address[3:2];
    full_m    = (mq.size() == DEPTH);
    exp_valid = (mq.size() != 0);
    exp_wait  = sys_rst || (avs_write && idx == 2'd0 && full_m) || (avs_read && !m_rdata);
    case (idx)
      2'd2:    rd_next = {14'd0, !exp_valid, full_m, 16'(mq.size())};
      2'd3:    rd_next = m_wc;
      default: rd_next = 32'd0;
    endcase
    @(negedge sys_clk);
    s_wait  = avs_waitrequest;
    s_valid = out_valid;
    s_rd    = avs_readdata;
    chk("waitrequest", {31'd0, avs_waitrequest}, {31'd0, exp_wait});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid) chk("out_data", out_data, mq[0]);
    chk("readdata", avs_readdata, m_rd);
    wr_done = avs_write && !exp_wait;
    rd_done = avs_read && !exp_wait;
    @(posedge sys_clk);
    if (sys_rst) begin
      mq.delete();
      m_wc    = 32'd0;
      m_rd    = 32'd0;
      m_rdata = 1'b0;
    end else begin
      clr = avs_write && idx == 2'd1 && avs_byteenable[0] && avs_writedata[0];
      if (clr) begin
        mq.delete();
        m_wc = 32'd0;
      end else begin
        if (exp_valid && out_ready) void'(mq.pop_front());
        if (avs_write && idx == 2'd0 && !full_m) begin
          mq.push_back(avs_writedata);
          m_wc = m_wc + 32'd1;
        end
      end
      if (m_rdata) m_rdata = 1'b0;
      else if (avs_read) begin
        m_rdata = 1'b1;
        m_rd    = rd_next;
      end
    end
    #1;
  endtask

  task automatic set_addr(input logic [1:0] idx);
    avs_address      = $urandom;
    avs_address[3:2] = idx;
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] be,
                          output int stalls);
    set_addr(idx);
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    stalls         = 0;
    wr_done        = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      cycle();
      if (wr_done) break;
      stalls++;
    end
    if (!wr_done) timeout("write_done");
    avs_write = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] idx, output logic [31:0] d);
    set_addr(idx);
    avs_read = 1'b1;
    rd_done  = 1'b0;
    d        = 'x;
    for (int n = 0; n < BUDGET; n++) begin
      cycle();
      if (rd_done) begin
        d = s_rd;
        break;
      end
    end
    if (!rd_done) timeout("read_done");
    avs_read = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    int st;
    for (int i = 0; i < n; i++) begin
      do_write(2'd0, base + 32'(i), 4'hF, st);
    end
  endtask

  task automatic clear_fifo();
    int st;
    do_write(2'd1, 32'h1, 4'h1, st);
  endtask

  initial begin
    int          st;
    logic [31:0] rd;
    int          r;

    sys_rst        = 1'b1;
    avs_address    = '0;
    avs_write      = 1'b0;
    avs_read       = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    out_ready      = 1'b0;
    rand_ready     = 1'b0;
    m_wc           = 32'd0;
    m_rd           = 32'd0;
    m_rdata        = 1'b0;

    tbl.push_back('{1'b1, 2'd2, 32'h0,      4'h0, 32'h0002_0000});
    tbl.push_back('{1'b0, 2'd0, 32'h11,     4'h0, 32'd0});
    tbl.push_back('{1'b0, 2'd2, 32'hFFFF,   4'hF, 32'd0});
    tbl.push_back('{1'b0, 2'd3, 32'hFFFF,   4'hF, 32'd0});
    tbl.push_back('{1'b1, 2'd3, 32'h0,      4'h0, 32'd1});
    tbl.push_back('{1'b1, 2'd2, 32'h0,      4'h0, 32'h0000_0001});
    tbl.push_back('{1'b0, 2'd1, 32'h1,      4'hE, 32'd0});
    tbl.push_back('{1'b1, 2'd2, 32'h0,      4'h0, 32'h0000_0001});
    tbl.push_back('{1'b0, 2'd1, 32'h2,      4'hF, 32'd0});
    tbl.push_back('{1'b1, 2'd3, 32'h0,      4'h0, 32'd1});
    tbl.push_back('{1'b1, 2'd0, 32'h0,      4'h0, 32'd0});
    tbl.push_back('{1'b1, 2'd1, 32'h0,      4'h0, 32'd0});
    tbl.push_back('{1'b0, 2'd1, 32'h1,      4'h1, 32'd0});
    tbl.push_back('{1'b1, 2'd2, 32'h0,      4'h0, 32'h0002_0000});
    tbl.push_back('{1'b1, 2'd3, 32'h0,      4'h0, 32'd0});

    // Reset state
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    chk("rst_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // Register map vectors
    foreach (tbl[i]) begin
      if (tbl[i].is_rd) begin
        do_read(tbl[i].idx, rd);
        chk($sformatf("tbl%0d_read", i), rd, tbl[i].exp);
      end else begin
        do_write(tbl[i].idx, tbl[i].wdata, tbl[i].be, st);
        chk($sformatf("tbl%0d_stalls", i), st, tbl[i].exp);
      end
    end

    // Fill to full, then a stalled 17th write released by one pop
    for (int i = 0; i < DEPTH; i++) begin
      do_write(2'd0, 32'hA0 + 32'(i), 4'hF, st);
      chk("fill_no_stall", st, 0);
    end
    do_read(2'd2, rd);
    chk("status_full", rd, 32'h0001_0010);
    set_addr(2'd0);
    avs_writedata = 32'hB0;
    avs_write     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("full_stall", {31'd0, s_wait}, 32'd1);
    end
    out_ready = 1'b1;
    cycle();
    chk("full_stall_pop_cycle", {31'd0, s_wait}, 32'd1);
    out_ready = 1'b0;
    cycle();
    chk("full_release", {31'd0, s_wait}, 32'd0);
    avs_write = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    chk("drained", {31'd0, s_valid}, 32'd0);
    out_ready = 1'b0;

    // Streaming across pointer wrap at constant level 3
    clear_fifo();
    push_n(3, 32'hC00);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_write(2'd0, 32'hD00 + 32'(i), 4'hF, st);
      chk("stream_no_stall", st, 0);
    end
    out_ready = 1'b0;
    do_read(2'd2, rd);
    chk("stream_level", rd, 32'h0000_0003);
    do_read(2'd3, rd);
    chk("stream_wcount", rd, 32'd43);

    // Simultaneous push and pop at level 5
    clear_fifo();
    push_n(5, 32'hE00);
    out_ready = 1'b1;
    do_write(2'd0, 32'hE05, 4'hF, st);
    out_ready = 1'b0;
    do_read(2'd2, rd);
    chk("pushpop_level", rd, 32'h0000_0005);

    // Clear coinciding with a pop
    clear_fifo();
    push_n(6, 32'hF00);
    out_ready = 1'b1;
    clear_fifo();
    cycle();
    chk("clear_out_valid", {31'd0, s_valid}, 32'd0);
    out_ready = 1'b0;
    do_read(2'd2, rd);
    chk("clear_status", rd, 32'h0002_0000);
    do_read(2'd3, rd);
    chk("clear_wcount", rd, 32'd0);

    // Reset during a read wait cycle
    push_n(2, 32'h500);
    do_read(2'd3, rd);
    chk("pre_rst_wcount", rd, 32'd2);
    set_addr(2'd3);
    avs_read = 1'b1;
    sys_rst  = 1'b1;
    cycle();
    sys_rst  = 1'b0;
    avs_read = 1'b0;
    cycle();
    chk("rst_rd_readdata", s_rd, 32'd0);
    chk("rst_rd_valid", {31'd0, s_valid}, 32'd0);

    // Reset mid-stall of a full write
    push_n(DEPTH, 32'h600);
    set_addr(2'd0);
    avs_writedata = 32'h6FF;
    avs_write     = 1'b1;
    cycle();
    cycle();
    chk("rst_wr_stalled", {31'd0, s_wait}, 32'd1);
    sys_rst = 1'b1;
    cycle();
    chk("rst_wr_wait", {31'd0, s_wait}, 32'd1);
    sys_rst   = 1'b0;
    avs_write = 1'b0;
    cycle();
    chk("rst_wr_valid", {31'd0, s_valid}, 32'd0);
    do_read(2'd2, rd);
    chk("rst_status", rd, 32'h0002_0000);
    do_read(2'd3, rd);
    chk("rst_wcount", rd, 32'd0);

    // Randomized traffic against the model
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      do_write(2'd0, $urandom, 4'($urandom), st);
      else if (r < 60) do_write(2'd1, $urandom, 4'($urandom), st);
      else if (r < 65) do_write(2'($urandom_range(2, 3)), $urandom, 4'hF, st);
      else if (r < 90) do_read(2'($urandom), rd);
      else             cycle();
    end
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
